// File: rtl/char_motion_if.sv
// Tile-map query channel between the character motion block and the
// tile-map lookup.
//   q_req   : query request, held until the transfer completes
//   q_x/q_y : queried pixel, stable while q_req is high
//   q_ack   : lookup acknowledge; q_solid is valid in this cycle
//   q_solid : 1 = queried pixel lies inside a solid tile
// master = motion block (issues queries), slave = tile-map lookup.
interface char_motion_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 10
);
    logic          q_req;
    logic [XW-1:0] q_x;
    logic [YW-1:0] q_y;
    logic          q_ack;
    logic          q_solid;

    modport master (
        output q_req,
        output q_x,
        output q_y,
        input  q_ack,
        input  q_solid
    );

    modport slave (
        input  q_req,
        input  q_x,
        input  q_y,
        output q_ack,
        output q_solid
    );
endinterface

// File: rtl/char_motion.sv
// Character motion for the platformer: divides sys_clk into movement ticks,
// walks the character one pixel per tick with bounds clamping, runs a
// ground/rise/fall vertical state machine and resolves collisions through
// tile-map queries on the tq channel.
// Ports:
//   sys_clk, rst_n : clock, asynchronous active-low reset
//   mov            : keypad {up, reserved, left, right}
//   tq             : tile-map query channel (master side)
//   char_X, char_Y : character position (Y grows downward)
//   grounded       : vertical state is GROUND
//   busy           : control FSM is not idle
//   tick_miss      : sticky, a tick arrived while busy
module char_motion #(
    parameter int unsigned TICK_DIV   = 1000000,
    parameter int unsigned XW         = 10,
    parameter int unsigned YW         = 10,
    parameter int unsigned X_MIN      = 0,
    parameter int unsigned X_MAX      = 480,
    parameter int unsigned Y_FLOOR    = 440,
    parameter int unsigned X_INIT     = 1,
    parameter int unsigned Y_INIT     = 0,
    parameter int unsigned JUMP_TICKS = 32
) (
    input  logic          sys_clk,
    input  logic          rst_n,
    input  logic [3:0]    mov,
    char_motion_if.master tq,
    output logic [XW-1:0] char_X,
    output logic [YW-1:0] char_Y,
    output logic          grounded,
    output logic          busy,
    output logic          tick_miss
);
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RW = $clog2(JUMP_TICKS + 1);

    localparam logic [CW-1:0] DIV_LAST  = CW'(TICK_DIV - 1);
    localparam logic [XW-1:0] X_MIN_C   = XW'(X_MIN);
    localparam logic [XW-1:0] X_MAX_C   = XW'(X_MAX);
    localparam logic [XW-1:0] X_INIT_C  = XW'(X_INIT);
    localparam logic [YW-1:0] Y_FLOOR_C = YW'(Y_FLOOR);
    localparam logic [YW-1:0] Y_INIT_C  = YW'(Y_INIT);
    localparam logic [RW-1:0] JUMP_C    = RW'(JUMP_TICKS);

    typedef enum logic [1:0] {ST_IDLE, ST_HQ, ST_VQ, ST_UPD} ctl_e;
    typedef enum logic [1:0] {VS_GROUND, VS_RISE, VS_FALL} vs_e;

    ctl_e          state_q, state_d;
    vs_e           vs_q, vs_d;
    logic [CW-1:0] div_q, div_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [RW-1:0] rc_q, rc_d;
    logic          up_q, up_d;
    logic          req_q, req_d;
    logic [XW-1:0] qx_q, qx_d;
    logic [YW-1:0] qy_q, qy_d;
    logic          grounded_q, busy_q, miss_q, miss_d;

    logic          tick_s;
    logic          go_right_s, go_left_s, hp_query_s;
    logic [XW-1:0] hp_qx_s, nx_s;
    logic          up_s, vp_query_s;
    logic [YW-1:0] vp_qy_s, vp_y_s;
    vs_e           vp_vs_s;
    logic [RW-1:0] vp_rc_s;
    logic          unused_mov_s;

    // mov[2] (down) has no effect on motion
    assign unused_mov_s = mov[2];

    // Movement tick divider: one-cycle tick when the counter wraps
    always_comb begin
        tick_s = (div_q == DIV_LAST);
        if (tick_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + CW'(1);
        end
    end

    // Horizontal plan from the live keypad; only used on the IDLE tick.
    // Bounds are checked before the step so X never wraps.
    always_comb begin
        go_right_s = mov[0] & ~mov[1];
        go_left_s  = mov[1] & ~mov[0];
        hp_query_s = (go_right_s && (x_q < X_MAX_C)) || (go_left_s && (x_q > X_MIN_C));
        if (go_right_s) begin
            hp_qx_s = x_q + XW'(1);
        end else begin
            hp_qx_s = x_q - XW'(1);
        end
    end

    // Vertical plan: decide whether a query is needed and, if not, the result.
    // In IDLE it is evaluated for a skipped horizontal move (X unchanged);
    // in H_Q it is evaluated for the X resolved by the acknowledged query.
    always_comb begin
        if (state_q == ST_IDLE) begin
            up_s = mov[3];
        end else begin
            up_s = up_q;
        end
        if ((state_q == ST_HQ) && !tq.q_solid) begin
            nx_s = qx_q;
        end else begin
            nx_s = x_q;
        end
        vp_query_s = 1'b0;
        vp_qy_s    = y_q;
        vp_y_s     = y_q;
        vp_vs_s    = vs_q;
        vp_rc_s    = rc_q;
        case (vs_q)
            VS_GROUND: begin
                if (up_s) begin
                    vp_vs_s = VS_RISE;
                    vp_rc_s = JUMP_C;
                end else if (y_q == Y_FLOOR_C) begin
                    vp_vs_s = VS_GROUND;
                end else begin
                    vp_query_s = 1'b1;
                    vp_qy_s    = y_q + YW'(1);
                end
            end
            VS_RISE: begin
                if ((y_q == '0) || (rc_q == '0)) begin
                    vp_vs_s = VS_FALL;
                end else begin
                    vp_query_s = 1'b1;
                    vp_qy_s    = y_q - YW'(1);
                end
            end
            VS_FALL: begin
                if (y_q >= Y_FLOOR_C) begin
                    vp_y_s  = Y_FLOOR_C;
                    vp_vs_s = VS_GROUND;
                end else begin
                    vp_query_s = 1'b1;
                    vp_qy_s    = y_q + YW'(1);
                end
            end
            default: begin
                vp_vs_s = VS_FALL;
            end
        endcase
    end

    // Control FSM next state. Position commits either at the tick edge (no
    // query) or at the edge of the final acknowledge. After an H_Q transfer
    // that needs a vertical query, q_req drops for one cycle and V_Q raises
    // it again, so every transfer sees its own request pulse.
    always_comb begin
        state_d = state_q;
        vs_d    = vs_q;
        x_d     = x_q;
        y_d     = y_q;
        rc_d    = rc_q;
        up_d    = up_q;
        req_d   = req_q;
        qx_d    = qx_q;
        qy_d    = qy_q;
        miss_d  = miss_q | (tick_s & busy_q);
        case (state_q)
            ST_IDLE: begin
                if (tick_s) begin
                    up_d = mov[3];
                    if (hp_query_s) begin
                        state_d = ST_HQ;
                        req_d   = 1'b1;
                        qx_d    = hp_qx_s;
                        qy_d    = y_q;
                    end else if (vp_query_s) begin
                        state_d = ST_VQ;
                        req_d   = 1'b1;
                        qx_d    = x_q;
                        qy_d    = vp_qy_s;
                    end else begin
                        state_d = ST_UPD;
                        vs_d    = vp_vs_s;
                        y_d     = vp_y_s;
                        rc_d    = vp_rc_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HQ: begin
                if (req_q && tq.q_ack) begin
                    req_d = 1'b0;
                    if (vp_query_s) begin
                        state_d = ST_VQ;
                        qx_d    = nx_s;
                        qy_d    = vp_qy_s;
                    end else begin
                        state_d = ST_UPD;
                        x_d     = nx_s;
                        vs_d    = vp_vs_s;
                        y_d     = vp_y_s;
                        rc_d    = vp_rc_s;
                    end
                end else begin
                    state_d = ST_HQ;
                end
            end
            ST_VQ: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (tq.q_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_UPD;
                    x_d     = qx_q;
                    case (vs_q)
                        VS_GROUND: begin
                            if (tq.q_solid) begin
                                vs_d = VS_GROUND;
                            end else begin
                                vs_d = VS_FALL;
                            end
                        end
                        VS_RISE: begin
                            if (tq.q_solid) begin
                                vs_d = VS_FALL;
                            end else begin
                                y_d  = qy_q;
                                rc_d = rc_q - RW'(1);
                            end
                        end
                        VS_FALL: begin
                            if (tq.q_solid) begin
                                vs_d = VS_GROUND;
                            end else begin
                                y_d = qy_q;
                            end
                        end
                        default: begin
                            vs_d = VS_FALL;
                        end
                    endcase
                end else begin
                    state_d = ST_VQ;
                end
            end
            ST_UPD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, position, handshake and status registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            vs_q       <= VS_FALL;
            div_q      <= '0;
            x_q        <= X_INIT_C;
            y_q        <= Y_INIT_C;
            rc_q       <= '0;
            up_q       <= 1'b0;
            req_q      <= 1'b0;
            qx_q       <= '0;
            qy_q       <= '0;
            grounded_q <= 1'b0;
            busy_q     <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_q       <= vs_d;
            div_q      <= div_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rc_q       <= rc_d;
            up_q       <= up_d;
            req_q      <= req_d;
            qx_q       <= qx_d;
            qy_q       <= qy_d;
            grounded_q <= (vs_d == VS_GROUND);
            busy_q     <= (state_d != ST_IDLE);
            miss_q     <= miss_d;
        end
    end

    assign tq.q_req  = req_q;
    assign tq.q_x    = qx_q;
    assign tq.q_y    = qy_q;
    assign char_X    = x_q;
    assign char_Y    = y_q;
    assign grounded  = grounded_q;
    assign busy      = busy_q;
    assign tick_miss = miss_q;
endmodule

// File: tb/tb_char_motion.sv
module tb_char_motion;
    localparam int TICK_DIV   = 16;
    localparam int XW         = 10;
    localparam int YW         = 10;
    localparam int X_MIN      = 0;
    localparam int X_MAX      = 480;
    localparam int Y_FLOOR    = 440;
    localparam int X_INIT     = 1;
    localparam int Y_INIT     = 0;
    localparam int JUMP_TICKS = 4;
    localparam int M_GND = 0, M_RISE = 1, M_FALL = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    mov;
    logic [XW-1:0] char_X;
    logic [YW-1:0] char_Y;
    logic          grounded, busy, tick_miss;

    char_motion_if #(.XW(XW), .YW(YW)) tile ();

    char_motion #(
        .TICK_DIV(TICK_DIV), .XW(XW), .YW(YW), .X_MIN(X_MIN), .X_MAX(X_MAX),
        .Y_FLOOR(Y_FLOOR), .X_INIT(X_INIT), .Y_INIT(Y_INIT), .JUMP_TICKS(JUMP_TICKS)
    ) dut (
        .sys_clk(clk), .rst_n(rst_n), .mov(mov), .tq(tile),
        .char_X(char_X), .char_Y(char_Y), .grounded(grounded),
        .busy(busy), .tick_miss(tick_miss)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (got === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Tile map shared by the responder and the reference model
    int map_mode;
    function automatic logic solid_fn(input int x, input int y);
        if (map_mode == 1) return ((y == 401 || y == 397) && x <= 200);
        return 1'b0;
    endfunction

    // Reference model: one movement tick at a time
    int mx, my, mvs, mrc;
    int eqx[$], eqy[$];
    task automatic model_reset();
        mx = X_INIT; my = Y_INIT; mvs = M_FALL; mrc = 0;
    endtask
    task automatic model_tick(input logic [3:0] m);
        int dx;
        logic s;
        eqx.delete(); eqy.delete();
        dx = (m[0] && !m[1]) ? 1 : ((m[1] && !m[0]) ? -1 : 0);
        if ((dx == 1 && mx < X_MAX) || (dx == -1 && mx > X_MIN)) begin
            eqx.push_back(mx + dx); eqy.push_back(my);
            if (!solid_fn(mx + dx, my)) mx = mx + dx;
        end
        if (mvs == M_GND) begin
            if (m[3]) begin
                mvs = M_RISE; mrc = JUMP_TICKS;
            end else if (my != Y_FLOOR) begin
                eqx.push_back(mx); eqy.push_back(my + 1);
                if (!solid_fn(mx, my + 1)) mvs = M_FALL;
            end
        end else if (mvs == M_RISE) begin
            if (my == 0 || mrc == 0) mvs = M_FALL;
            else begin
                eqx.push_back(mx); eqy.push_back(my - 1);
                s = solid_fn(mx, my - 1);
                if (s) mvs = M_FALL;
                else begin my = my - 1; mrc = mrc - 1; end
            end
        end else begin
            if (my >= Y_FLOOR) begin
                my = Y_FLOOR; mvs = M_GND;
            end else begin
                eqx.push_back(mx); eqy.push_back(my + 1);
                if (solid_fn(mx, my + 1)) mvs = M_GND;
                else my = my + 1;
            end
        end
    endtask

    // Tile-map responder and position-change monitor, all on the falling edge
    int cyc = 0, chg_cyc = 0, ack_cyc = 0, wait_left = 0, ack_delay = 0;
    bit started = 0, hold = 0;
    logic [XW-1:0] sx, px;
    logic [YW-1:0] sy, py;
    int lx[$], ly[$];
    initial begin
        tile.q_ack = 1'b0;
        tile.q_solid = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (char_X !== px || char_Y !== py) chg_cyc = cyc;
            px = char_X; py = char_Y;
            tile.q_ack = 1'b0;
            tile.q_solid = 1'($urandom);
            if (rst_n !== 1'b1) begin
                started = 0;
            end else begin
                if (tile.q_req === 1'b1 && !started) begin
                    started = 1; sx = tile.q_x; sy = tile.q_y;
                    wait_left = (ack_delay < 0) ? int'($urandom_range(3, 0)) : ack_delay;
                end
                if (started) begin
                    if (!hold) begin
                        if (wait_left > 0) wait_left--;
                        else begin
                            chk("q_x_stable", tile.q_x, sx);
                            chk("q_y_stable", tile.q_y, sy);
                            tile.q_ack = 1'b1;
                            tile.q_solid = solid_fn(tile.q_x, tile.q_y);
                            lx.push_back(tile.q_x); ly.push_back(tile.q_y);
                            ack_cyc = cyc; started = 0;
                        end
                    end
                end else if (($urandom & 3) == 0) begin
                    tile.q_ack = 1'b1;  // stray ack while idle must be ignored
                end
            end
        end
    end

    bit miss_exp = 0;

    // One movement tick: drive mov, wait for the FSM to run, compare with model
    task automatic step(input logic [3:0] m, input int hold_cyc);
        int t, bx, by;
        bx = mx; by = my;
        mov = m;
        lx.delete(); ly.delete();
        hold = (hold_cyc > 0);
        t = 0;
        while (busy !== 1'b1 && t < 4 * TICK_DIV) begin @(negedge clk); t++; end
        chk("tick_seen", busy, 1);
        if (hold_cyc > 0) begin
            repeat (hold_cyc) @(negedge clk);
            hold = 0;
        end
        t = 0;
        while (busy !== 1'b0 && t < 100) begin @(negedge clk); t++; end
        chk("busy_done", busy, 0);
        model_tick(m);
        chk("char_X", char_X, mx);
        chk("char_Y", char_Y, my);
        chk("grounded", grounded, (mvs == M_GND));
        chk("tick_miss", tick_miss, miss_exp);
        chk("n_queries", lx.size(), eqx.size());
        for (int i = 0; i < eqx.size() && i < lx.size(); i++) begin
            chk("query_x", lx[i], eqx[i]);
            chk("query_y", ly[i], eqy[i]);
        end
        if (lx.size() > 0 && (mx != bx || my != by)) chk("commit_latency", chg_cyc, ack_cyc + 1);
    endtask

    task automatic do_reset(input int mode);
        rst_n = 1'b0; mov = 4'b0000; hold = 0; map_mode = mode; miss_exp = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int t;
        logic [3:0] rm;
        rst_n = 1'b0; mov = 4'b0000; map_mode = 0; ack_delay = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_char_X", char_X, X_INIT);
        chk("rst_char_Y", char_Y, Y_INIT);
        chk("rst_q_req", tile.q_req, 0);
        chk("rst_q_x", tile.q_x, 0);
        chk("rst_q_y", tile.q_y, 0);
        chk("rst_grounded", grounded, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick_miss", tick_miss, 0);

        // Reset asserted while a query is outstanding
        rst_n = 1'b1; hold = 1;
        t = 0;
        while (tile.q_req !== 1'b1 && t < 4 * TICK_DIV) begin @(negedge clk); t++; end
        chk("req_before_reset", tile.q_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midq_q_req", tile.q_req, 0);
        chk("midq_char_X", char_X, X_INIT);
        chk("midq_char_Y", char_Y, Y_INIT);
        chk("midq_grounded", grounded, 0);
        chk("midq_busy", busy, 0);
        hold = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Free fall to the floor with nothing solid
        ack_delay = -1;
        repeat (Y_FLOOR + 1) step(4'b0000, 0);

        // Walking, blocked diagonal, both X bounds, and a jump
        repeat (99) step(4'b0001, 0);
        step(4'b0011, 0);
        repeat (101) step(4'b0010, 0);
        repeat (50) step(4'b0001, 0);
        step(4'b1000, 0);
        repeat (10) step(4'b0000, 0);
        repeat (431) step(4'b0001, 0);

        // Platform map: land on a ledge, bump the ceiling, walk off the edge
        do_reset(1);
        repeat (401) step(4'b0000, 0);
        repeat (199) step(4'b0001, 0);
        ack_delay = 3;
        step(4'b1000, 0);
        repeat (6) step(4'b0000, 0);
        ack_delay = -1;
        step(4'b0001, 0);
        repeat (40) step(4'b0000, 0);

        // Random keypad activity
        repeat (150) begin
            rm = 4'($urandom);
            step(rm, 0);
        end

        // Withheld acknowledge longer than a tick period
        miss_exp = 1;
        step((mx > X_MIN) ? 4'b0010 : 4'b0001, 20);
        step(4'b0000, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end
endmodule
